// File: rtl/frame_assembler_if.sv
// Bus bundle between the Port receiver / switch logic (master) and the frame assembler (slave).
interface frame_assembler_if #(
  parameter int unsigned data_len = 8,
  parameter int unsigned mac_len  = 12
);
  logic                   rec_complete;
  logic [data_len-1:0]    dout;
  logic [mac_len*8-1:0]   my_address;
  logic                   frame_valid;
  logic [mac_len*8-1:0]   frame_dst;
  logic [mac_len*8-1:0]   frame_src;
  logic [data_len-1:0]    frame_len;
  logic                   frame_ack;
  logic [data_len-1:0]    pl_data;
  logic                   pl_empty;
  logic                   pl_rd_en;
  logic                   frame_err;
  logic [1:0]             err_code;

  modport master (
    output rec_complete, dout, my_address, frame_ack, pl_rd_en,
    input  frame_valid, frame_dst, frame_src, frame_len, pl_data, pl_empty,
           frame_err, err_code
  );

  modport slave (
    input  rec_complete, dout, my_address, frame_ack, pl_rd_en,
    output frame_valid, frame_dst, frame_src, frame_len, pl_data, pl_empty,
           frame_err, err_code
  );
endinterface

// File: rtl/frame_assembler.sv
// Parses dst/src/len/payload frames from a byte stream, buffers frames for this
// station (or broadcast) and holds them until acked; everything else is dropped.
module frame_assembler #(
  parameter int unsigned data_len       = 8,
  parameter int unsigned mac_len        = 12,
  parameter int unsigned max_payload    = 16,
  parameter int unsigned timeout_cycles = 1024
) (
  input logic              clk,
  input logic              reset,
  frame_assembler_if.slave bus
);
  localparam int unsigned MW   = mac_len * 8;
  localparam int unsigned MAXB = (mac_len > max_payload) ? mac_len : max_payload;
  localparam int unsigned CW   = $clog2(MAXB + 1);
  localparam int unsigned PW   = $clog2(max_payload) + 1;
  localparam int unsigned AW   = (max_payload > 1) ? $clog2(max_payload) : 1;
  localparam int unsigned TW   = $clog2(timeout_cycles + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DST, S_SRC, S_LEN, S_PAYLOAD, S_DISCARD, S_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [MW-1:0]       dst_q, dst_d;
  logic [MW-1:0]       src_q, src_d;
  logic [data_len-1:0] len_q, len_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [data_len-1:0] pl_buf_q [max_payload];
  logic [data_len-1:0] pl_buf_d [max_payload];
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;
  logic                pl_empty_w;
  logic                for_us_w;

  assign pl_empty_w = (state_q != S_HOLD) || (rd_ptr_q == wr_ptr_q);
  assign for_us_w   = (dst_q == bus.my_address) || (dst_q == {mac_len{8'h46}});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    dst_d    = dst_q;
    src_d    = src_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pl_buf_d = pl_buf_q;
    err_d    = 1'b0;
    code_d   = 2'd0;

    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        tmo_d    = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        if (bus.rec_complete) begin
          dst_d   = {dst_q[MW-data_len-1:0], bus.dout};
          cnt_d   = CW'(1);
          state_d = S_DST;
        end
      end

      S_HOLD: begin
        if (bus.pl_rd_en && !pl_empty_w) rd_ptr_d = rd_ptr_q + PW'(1);
        // Ack takes priority over a pop in the same cycle; a stray byte is always dropped.
        if (bus.frame_ack) begin
          state_d  = S_IDLE;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
        end
        if (bus.rec_complete) begin
          err_d  = 1'b1;
          code_d = 2'd3;
        end
      end

      default: begin
        if (bus.rec_complete) begin
          tmo_d = '0;
          case (state_q)
            S_DST: begin
              dst_d = {dst_q[MW-data_len-1:0], bus.dout};
              if (32'(cnt_q) == mac_len - 1) begin
                cnt_d   = '0;
                state_d = S_SRC;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
            S_SRC: begin
              src_d = {src_q[MW-data_len-1:0], bus.dout};
              if (32'(cnt_q) == mac_len - 1) begin
                cnt_d   = '0;
                state_d = S_LEN;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
            S_LEN: begin
              len_d = bus.dout;
              cnt_d = '0;
              if (bus.dout == '0 || 32'(bus.dout) > max_payload) begin
                err_d   = 1'b1;
                code_d  = 2'd1;
                state_d = S_IDLE;
              end else if (for_us_w) begin
                state_d = S_PAYLOAD;
              end else begin
                state_d = S_DISCARD;
              end
            end
            S_PAYLOAD: begin
              pl_buf_d[wr_ptr_q[AW-1:0]] = bus.dout;
              wr_ptr_d = wr_ptr_q + PW'(1);
              if (32'(wr_ptr_q) + 1 == 32'(len_q)) state_d = S_HOLD;
            end
            S_DISCARD: begin
              cnt_d = cnt_q + CW'(1);
              if (32'(cnt_q) + 1 == 32'(len_q)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
          endcase
        end else if (32'(tmo_q) == timeout_cycles - 1) begin
          err_d   = 1'b1;
          code_d  = 2'd2;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      dst_q    <= '0;
      src_q    <= '0;
      len_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
      for (int unsigned i = 0; i < max_payload; i++) pl_buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
      code_q   <= code_d;
      pl_buf_q <= pl_buf_d;
    end
  end

  assign bus.frame_valid = (state_q == S_HOLD);
  assign bus.frame_dst   = dst_q;
  assign bus.frame_src   = src_q;
  assign bus.frame_len   = len_q;
  assign bus.pl_data     = pl_buf_q[rd_ptr_q[AW-1:0]];
  assign bus.pl_empty    = pl_empty_w;
  assign bus.frame_err   = err_q;
  assign bus.err_code    = code_q;
endmodule
